// File: rtl/quant_pkg.sv
// Shared constants and types for the requantization scheduler.
package quant_pkg;

   localparam int N_IN_DEF  = 32;
   localparam int N_OUT_DEF = 8;

   // M0 is an unsigned fraction with this many bits
   localparam int FRAC_BITS = 32;

   // Saturation limits for the default output width
   localparam int MAX_OUT = 2 ** (N_OUT_DEF - 1) - 1;
   localparam int MIN_OUT = -(2 ** (N_OUT_DEF - 1));

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/requant_pipe.sv
// Three-stage requantization datapath: |a| capture, multiply, round/saturate.
module requant_pipe
   import quant_pkg::*;
#(
   parameter int DATA_W  = N_IN_DEF,
   parameter int OUT_W   = N_OUT_DEF,
   parameter int COEF_W  = FRAC_BITS,
   parameter int SHIFT_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     in_vld,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic [COEF_W-1:0]        in_m0,
   input  logic [SHIFT_W-1:0]       in_shift,
   input  logic                     in_last,
   output logic                     out_vld,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_last
);

   localparam int MAG_W  = DATA_W + 1;
   // |a| <= 2^(DATA_W-1), so the product always fits in DATA_W+COEF_W bits
   localparam int PROD_W = DATA_W + COEF_W;
   localparam logic [PROD_W-1:0] POS_LIM = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic [PROD_W-1:0] NEG_LIM = POS_LIM + 1'b1;

   // One extra bit so that |most negative| is representable
   function automatic logic [MAG_W-1:0] abs_ext(input logic signed [DATA_W-1:0] a);
      logic signed [MAG_W-1:0] e;
      e = MAG_W'(a);
      abs_ext = $unsigned(a[DATA_W-1] ? -e : e);
   endfunction

   // Drop 31+shift bits, round half away from zero on the magnitude, clamp, reapply sign
   function automatic logic signed [OUT_W-1:0] round_sat(input logic [PROD_W-1:0] p,
                                                         input logic [SHIFT_W-1:0] sh,
                                                         input logic neg);
      logic [PROD_W-1:0] q;
      logic [PROD_W-1:0] r;
      q = p >> (COEF_W - 1 + int'(sh));
      r = (q >> 1) + {{(PROD_W-1){1'b0}}, q[0]};
      if (!neg)
         round_sat = (r > POS_LIM) ? POS_LIM[OUT_W-1:0] : r[OUT_W-1:0];
      else
         round_sat = (r > NEG_LIM) ? {1'b1, {(OUT_W-1){1'b0}}} : -r[OUT_W-1:0];
   endfunction

   logic                 vld_p0;
   logic                 neg_p0;
   logic [MAG_W-1:0]     mag_p0;
   logic [COEF_W-1:0]    m0_p0;
   logic [SHIFT_W-1:0]   sh_p0;
   logic                 last_p0;

   logic                 vld_p1;
   logic                 neg_p1;
   logic [PROD_W-1:0]    prod_p1;
   logic [SHIFT_W-1:0]   sh_p1;
   logic                 last_p1;

   // ---- stage p0: capture sign, magnitude and per-channel coefficients
   always_ff @(posedge clk) begin
      if (rst)
         vld_p0 <= 1'b0;
      else if (en)
         vld_p0 <= in_vld;
      if (en) begin
         neg_p0  <= in_data[DATA_W-1];
         mag_p0  <= abs_ext(in_data);
         m0_p0   <= in_m0;
         sh_p0   <= in_shift;
         last_p0 <= in_last;
      end
   end

   // ---- stage p1: unsigned magnitude x M0
   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else if (en)
         vld_p1 <= vld_p0;
      if (en) begin
         neg_p1  <= neg_p0;
         prod_p1 <= PROD_W'(mag_p0) * PROD_W'(m0_p0);
         sh_p1   <= sh_p0;
         last_p1 <= last_p0;
      end
   end

   // ---- stage p2: shift, round and saturate into the output register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
      end else if (en) begin
         out_vld  <= vld_p1;
         out_data <= round_sat(prod_p1, sh_p1, neg_p1);
         out_last <= last_p1;
      end
   end

endmodule

// File: rtl/quant_sched.sv
// Layer scheduler: per-channel config table, channel counter, layer FSM and
// handshakes around the shared requantization pipeline.
module quant_sched
   import quant_pkg::*;
#(
   parameter int          N_IN          = N_IN_DEF,
   parameter int          N_OUT         = N_OUT_DEF,
   parameter int          N_CH          = 16,
   parameter int          SHIFT_W       = 5,
   parameter logic [31:0] M0_DEFAULT    = 32'd1932735283,
   parameter int          SHIFT_DEFAULT = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_we,
   input  logic [$clog2(N_CH)-1:0]   cfg_addr,
   input  logic [31:0]               cfg_m0,
   input  logic [SHIFT_W-1:0]        cfg_shift,
   output logic                      cfg_err,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [N_IN-1:0]    in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [N_OUT-1:0]   out_data,
   output logic                      out_last,
   output logic                      busy
);

   localparam int AW = $clog2(N_CH);

   state_t              state;
   logic [AW-1:0]       ch;

   // cfg_*_tab receives writes; act_*_tab is frozen for the layer in flight
   logic [31:0]         cfg_m0_tab [N_CH];
   logic [SHIFT_W-1:0]  cfg_sh_tab [N_CH];
   logic [31:0]         act_m0_tab [N_CH];
   logic [SHIFT_W-1:0]  act_sh_tab [N_CH];

   logic                pipe_en;
   logic                in_hs;
   logic                out_hs;
   logic                last_ch;
   logic                cfg_ok;
   logic [31:0]         lk_m0;
   logic [SHIFT_W-1:0]  lk_sh;

   assign pipe_en  = !out_valid || out_ready;
   assign in_ready = !rst && (state != ST_DRAIN) && pipe_en;
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;
   assign last_ch  = (ch == AW'(N_CH - 1));
   assign cfg_ok   = cfg_we && (state == ST_IDLE) &&
                     ({{(32-AW){1'b0}}, cfg_addr} < 32'(N_CH));

   // In IDLE the first channel reads the live table (pre-write); afterwards the frozen copy
   always_comb begin
      lk_m0 = act_m0_tab[ch];
      lk_sh = act_sh_tab[ch];
      if (state == ST_IDLE) begin
         lk_m0 = cfg_m0_tab[ch];
         lk_sh = cfg_sh_tab[ch];
      end
   end

   // Layer FSM, channel counter and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         ch      <= '0;
         busy    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && !cfg_ok;
         if (in_hs)
            ch <= last_ch ? '0 : ch + 1'b1;
         case (state)
            ST_IDLE: begin
               if (in_hs) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (in_hs && last_ch)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (out_hs && out_last) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Config table: writes land in IDLE only; the active copy tracks it until a layer starts
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            cfg_m0_tab[i] <= M0_DEFAULT;
            cfg_sh_tab[i] <= SHIFT_W'(SHIFT_DEFAULT);
            act_m0_tab[i] <= M0_DEFAULT;
            act_sh_tab[i] <= SHIFT_W'(SHIFT_DEFAULT);
         end
      end else begin
         if (state == ST_IDLE) begin
            act_m0_tab <= cfg_m0_tab;
            act_sh_tab <= cfg_sh_tab;
         end
         if (cfg_ok) begin
            cfg_m0_tab[cfg_addr] <= cfg_m0;
            cfg_sh_tab[cfg_addr] <= cfg_shift;
         end
      end
   end

   requant_pipe #(
      .DATA_W  (N_IN),
      .OUT_W   (N_OUT),
      .COEF_W  (FRAC_BITS),
      .SHIFT_W (SHIFT_W)
   ) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .en       (pipe_en),
      .in_vld   (in_hs),
      .in_data  (in_data),
      .in_m0    (lk_m0),
      .in_shift (lk_sh),
      .in_last  (last_ch),
      .out_vld  (out_valid),
      .out_data (out_data),
      .out_last (out_last)
   );

endmodule
